accel_sample_sequencer: RTL

//  Sequences accelerometer X/Y register reads at a fixed sample rate and feeds smoothing_filter.

---
 rtl/accel_sample_sequencer.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/accel_sample_sequencer.sv
// Sequences X/Y accelerometer reads on a fixed tick and drives smoothing_filter inputs.
// Optional: define SEQ_OVERRUN_CNT_EN to add the overrun_cnt output.
module accel_sample_sequencer #(
  parameter int         SAMPLE_DIV = 5000,
  parameter int         TIMEOUT    = 255,
  parameter int         UPD_HI     = 4,
  parameter int         PRIME_CNT  = 8,
  parameter logic [5:0] ADDR_X     = 6'h32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  SW,
  output logic        rd_req,
  output logic [5:0]  rd_addr,
  input  logic        rd_ack,
  input  logic [15:0] rd_data,
  output logic [15:0] data_x,
  output logic [15:0] data_y,
  output logic        data_update,
  output logic [1:0]  sw_filt,
  output logic        rd_err
`ifdef SEQ_OVERRUN_CNT_EN
  , output logic [7:0] overrun_cnt
`endif
);
  localparam logic [5:0] ADDR_Y = ADDR_X + 6'd2;
  localparam int CW = $clog2(SAMPLE_DIV);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam int UW = $clog2(UPD_HI + 2);
  localparam int PW = $clog2(PRIME_CNT + 1);

  typedef enum logic [2:0] {IDLE, RD_X, RD_Y, UPD_H, UPD_L} state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            tick;
  logic [1:0]      sw_s1_q, sw_req_q, sw_filt_q;
  logic [WW-1:0]   wcnt_q;
  logic [UW-1:0]   ucnt_q;
  logic [PW-1:0]   prime_q;
  logic [15:0]     x_new_q, y_new_q, data_x_q, data_y_q;
  logic [5:0]      rd_addr_q;
  logic            rd_req_q, upd_q, rd_err_q;

  assign tick  = (cnt_q == CW'(SAMPLE_DIV - 1));
  assign cnt_d = tick ? '0 : cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      sw_s1_q  <= 2'b00;
      sw_req_q <= 2'b00;
    end else begin
      cnt_q    <= cnt_d;
      sw_s1_q  <= SW;
      sw_req_q <= sw_s1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      wcnt_q    <= '0;
      ucnt_q    <= '0;
      prime_q   <= '0;
      x_new_q   <= '0;
      y_new_q   <= '0;
      data_x_q  <= '0;
      data_y_q  <= '0;
      rd_addr_q <= ADDR_X;
      rd_req_q  <= 1'b0;
      upd_q     <= 1'b0;
      sw_filt_q <= 2'b00;
      rd_err_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (tick) begin
          state_q   <= RD_X;
          rd_req_q  <= 1'b1;
          rd_addr_q <= ADDR_X;
          wcnt_q    <= '0;
          // Depth change: the normal update plus PRIME_CNT repeats refill the filter history
          if (sw_req_q != sw_filt_q) begin
            sw_filt_q <= sw_req_q;
            prime_q   <= PW'(PRIME_CNT);
          end else begin
            prime_q   <= '0;
          end
        end
        RD_X: begin
          if (rd_ack) begin
            x_new_q   <= rd_data;
            rd_addr_q <= ADDR_Y;
            wcnt_q    <= '0;
            state_q   <= RD_Y;
          end else if (wcnt_q == WW'(TIMEOUT - 1)) begin
            rd_req_q <= 1'b0;
            rd_err_q <= 1'b1;
            state_q  <= RD_Y;
          end else begin
            wcnt_q <= wcnt_q + 1'b1;
          end
        end
        RD_Y: begin
          // After an X timeout the request is re-raised here; a stale X ack in that cycle is ignored
          if (!rd_req_q) begin
            rd_req_q  <= 1'b1;
            rd_addr_q <= ADDR_Y;
            wcnt_q    <= '0;
          end else if (rd_ack || wcnt_q == WW'(TIMEOUT - 1)) begin
            if (rd_ack) y_new_q <= rd_data;
            else        rd_err_q <= 1'b1;
            rd_req_q  <= 1'b0;
            rd_addr_q <= ADDR_X;
            ucnt_q    <= '0;
            state_q   <= UPD_H;
          end else begin
            wcnt_q <= wcnt_q + 1'b1;
          end
        end
        UPD_H: begin
          if (ucnt_q == '0) begin
            data_x_q <= x_new_q;
            data_y_q <= y_new_q;
          end
          if (ucnt_q == UW'(1)) upd_q <= 1'b1;
          if (ucnt_q == UW'(UPD_HI + 1)) begin
            upd_q   <= 1'b0;
            ucnt_q  <= '0;
            state_q <= UPD_L;
          end else begin
            ucnt_q <= ucnt_q + 1'b1;
          end
        end
        UPD_L: begin
          if (ucnt_q == UW'(UPD_HI - 1)) begin
            ucnt_q <= '0;
            if (prime_q != '0) begin
              prime_q <= prime_q - 1'b1;
              state_q <= UPD_H;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            ucnt_q <= ucnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef SEQ_OVERRUN_CNT_EN
  logic [7:0] ovr_q;
  always_ff @(posedge clk) begin
    if (!reset_n)                                        ovr_q <= 8'h00;
    else if (tick && state_q != IDLE && ovr_q != 8'hFF) ovr_q <= ovr_q + 8'h01;
  end
  assign overrun_cnt = ovr_q;
`endif

  assign rd_req      = rd_req_q;
  assign rd_addr     = rd_addr_q;
  assign data_x      = data_x_q;
  assign data_y      = data_y_q;
  assign data_update = upd_q;
  assign sw_filt     = sw_filt_q;
  assign rd_err      = rd_err_q;
endmodule
